// File: rtl/uart_cmd_player.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_player
//  Description : Plays a table of command words out over a byte-wide UART
//                handshake, one byte at a time, optionally looping.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_player #(
    parameter int CMDW     = 64,
    parameter int LINES    = 10,
    parameter int GAPCYC   = 0,
    parameter int MSBFIRST = 1,
    localparam int c_AW    = (LINES > 1) ? $clog2(LINES) : 1,
    localparam int c_NW    = $clog2(LINES + 1)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            wr_en,
    input  logic [c_AW-1:0] wr_addr,
    input  logic [CMDW-1:0] wr_data,
    input  logic [c_NW-1:0] nlines,
    input  logic            loop,
    input  logic            start,
    input  logic            abort,
    output logic [7:0]      txdata,
    output logic            txstart,
    input  logic            txready,
    output logic            busy,
    output logic            done,
    output logic [c_AW-1:0] line,
    output logic [15:0]     pass_cnt
);

    localparam int c_NB = CMDW / 8;
    localparam int c_BW = $clog2(c_NB + 1);
    localparam int c_GW = (GAPCYC > 0) ? $clog2(GAPCYC + 1) : 1;
    localparam logic [c_BW-1:0] c_NBYTES   = c_BW'(c_NB);
    localparam logic [c_BW-1:0] c_BONE     = c_BW'(1);
    localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'((GAPCYC > 0) ? GAPCYC - 1 : 0);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_LOAD   = 3'd1;
    localparam logic [2:0] c_ISSUE  = 3'd2;
    localparam logic [2:0] c_WAITLO = 3'd3;
    localparam logic [2:0] c_WAITHI = 3'd4;
    localparam logic [2:0] c_GAP    = 3'd5;
    localparam logic [2:0] c_DONE   = 3'd6;

    logic [CMDW-1:0] r_table [LINES];
    logic [2:0]      r_state;
    logic [CMDW-1:0] r_shift;
    logic [c_BW-1:0] r_bcnt;
    logic [c_GW-1:0] r_gap;
    logic [c_AW-1:0] r_line;
    logic [c_NW-1:0] r_nlines;
    logic [15:0]     r_pass;
    logic [7:0]      r_txdata;

    logic [7:0]      w_cur_byte;
    logic [CMDW-1:0] w_shift_next;
    logic            w_txstart;
    logic            w_last_line;
    logic            w_advance;
    logic            w_wr_ok;

    generate
        if (MSBFIRST != 0) begin : g_msb_first
            assign w_cur_byte   = r_shift[CMDW-1 -: 8];
            assign w_shift_next = r_shift << 8;
        end else begin : g_lsb_first
            assign w_cur_byte   = r_shift[7:0];
            assign w_shift_next = r_shift >> 8;
        end
    endgenerate

    assign w_wr_ok     = 32'(wr_addr) < LINES;
    assign w_txstart   = (r_state == c_ISSUE) && txready;
    assign w_last_line = (32'(r_line) + 32'd1) >= 32'(r_nlines);
    assign w_advance   = ((r_state == c_WAITHI) && txready && (r_bcnt == c_BONE) && (GAPCYC == 0))
                       || ((r_state == c_GAP) && (r_gap == c_GAP_LAST));

    // The table is deliberately not reset so its contents survive rstn.
    always_ff @(posedge clk) begin
        if (wr_en && w_wr_ok) begin
            r_table[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= c_IDLE;
            r_shift  <= '0;
            r_bcnt   <= '0;
            r_gap    <= '0;
            r_line   <= '0;
            r_nlines <= '0;
            r_pass   <= '0;
            r_txdata <= '0;
        end else begin
            // A byte handed over in the abort cycle is still captured so txdata stays stable.
            if (w_txstart) begin
                r_txdata <= w_cur_byte;
            end
            if (abort) begin
                r_state <= c_IDLE;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (start && (nlines != '0)) begin
                            r_nlines <= (32'(nlines) > LINES) ? c_NW'(LINES) : nlines;
                            r_line   <= '0;
                            r_state  <= c_LOAD;
                        end
                    end
                    c_LOAD: begin
                        r_shift <= r_table[r_line];
                        r_bcnt  <= c_NBYTES;
                        r_state <= c_ISSUE;
                    end
                    c_ISSUE: begin
                        if (txready) begin
                            r_state <= c_WAITLO;
                        end
                    end
                    c_WAITLO: begin
                        if (!txready) begin
                            r_state <= c_WAITHI;
                        end
                    end
                    c_WAITHI: begin
                        if (txready) begin
                            r_shift <= w_shift_next;
                            r_bcnt  <= r_bcnt - c_BONE;
                            if (r_bcnt != c_BONE) begin
                                r_state <= c_ISSUE;
                            end else if (GAPCYC > 0) begin
                                r_gap   <= '0;
                                r_state <= c_GAP;
                            end
                        end
                    end
                    c_GAP: begin
                        if (r_gap != c_GAP_LAST) begin
                            r_gap <= r_gap + c_GW'(1);
                        end
                    end
                    c_DONE: begin
                        r_state <= c_IDLE;
                    end
                    default: begin
                        r_state <= c_IDLE;
                    end
                endcase
                if (w_advance) begin
                    if (!w_last_line) begin
                        r_line  <= r_line + c_AW'(1);
                        r_state <= c_LOAD;
                    end else begin
                        r_pass  <= r_pass + 16'd1;
                        r_line  <= '0;
                        r_state <= loop ? c_LOAD : c_DONE;
                    end
                end
            end
        end
    end

    assign txstart  = w_txstart;
    assign txdata   = w_txstart ? w_cur_byte : r_txdata;
    assign busy     = (r_state != c_IDLE) && (r_state != c_DONE);
    assign done     = (r_state == c_DONE);
    assign line     = r_line;
    assign pass_cnt = r_pass;

endmodule
`default_nettype wire
